// File: rtl/plru_victim_select.sv
// plru_victim_select
//   Per-set tree-PLRU replacement engine. It serves one request at a time and
//   walks the tree one level per cycle.
//   TOUCH  (req_op=0) marks req_way as most-recently-used in req_set.
//   VICTIM (req_op=1) walks away from the recent side at every node to pick
//                     the eviction way, then marks that way MRU.
// Ports
//   clk, rst           clock, synchronous active-high reset
//   req_valid/ready    request handshake; ready only while idle
//   req_op/set/way     operation, set index, way to touch (ignored for VICTIM)
//   resp_valid         one-cycle completion pulse; it cannot be back-pressured
//   resp_way/set/plru  result way, set, and the tree value written back.
//                      These hold their last values between pulses.
// Tree encoding: bit[idx]=0 means the last access went to the lower child
//   (2*idx+1), and 1 means the upper child (2*idx+2). Way bits are read MSB first.
module plru_victim_select #(
  parameter int WAYS     = 16,
  parameter int NUM_SETS = 64,
  localparam int PLRU_BITS = WAYS - 1,
  localparam int LVL       = $clog2(WAYS),
  localparam int SW        = $clog2(NUM_SETS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_op,
  input  logic [SW-1:0]        req_set,
  input  logic [LVL-1:0]       req_way,
  output logic                 resp_valid,
  output logic [LVL-1:0]       resp_way,
  output logic [SW-1:0]        resp_set,
  output logic [PLRU_BITS-1:0] resp_plru
);

  // The node index can step one level past the leaves on the final walk
  // cycle. That value is never used, but LVL+1 bits keep it from aliasing.
  localparam int IW = LVL + 1;

  typedef enum logic [1:0] {IDLE, LOAD, WALK, WRITE} state_t;

  state_t st, nxt;

  logic [PLRU_BITS-1:0] mem [NUM_SETS];

  logic                 op_q;
  logic [SW-1:0]        set_q;
  logic [LVL-1:0]       way_q;
  logic [PLRU_BITS-1:0] w;       // working tree
  logic [LVL-1:0]       lvl_q;   // current way bit, counts down to 0
  logic [IW-1:0]        idx_q;   // current node
  logic [LVL-1:0]       vic_q;   // victim way assembled during the walk

  // Values shown on the response outputs between pulses
  logic [LVL-1:0]       way_h;
  logic [SW-1:0]        set_h;
  logic [PLRU_BITS-1:0] plru_h;

  logic [PLRU_BITS-1:0] w_sh, node_mask;
  logic [LVL-1:0]       way_sh, lvl_mask;
  logic                 d;

  // Decision at the current node: TOUCH follows the way bit, VICTIM goes
  // to the side that was not used most recently.
  always_comb begin
    w_sh      = w >> idx_q;
    way_sh    = way_q >> lvl_q;
    node_mask = PLRU_BITS'(1) << idx_q;
    lvl_mask  = LVL'(1) << lvl_q;
    d         = op_q ? ~w_sh[0] : way_sh[0];
  end

  always_ff @(posedge clk) begin
    if (rst) st <= IDLE;
    else     st <= nxt;
  end

  always_comb begin
    nxt        = st;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (st)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) nxt = LOAD;
      end
      LOAD:  nxt = WALK;
      WALK:  if (lvl_q == '0) nxt = WRITE;
      WRITE: begin
        resp_valid = 1'b1;
        nxt        = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SETS; i++) mem[i] <= '0;
      op_q   <= 1'b0;
      set_q  <= '0;
      way_q  <= '0;
      w      <= '0;
      lvl_q  <= '0;
      idx_q  <= '0;
      vic_q  <= '0;
      way_h  <= '0;
      set_h  <= '0;
      plru_h <= '0;
    end else begin
      case (st)
        IDLE: if (req_valid) begin
          op_q  <= req_op;
          set_q <= req_set;
          way_q <= req_way;
        end
        LOAD: begin
          w     <= mem[set_q];
          lvl_q <= LVL'(LVL - 1);
          idx_q <= '0;
          vic_q <= '0;
        end
        WALK: begin
          w     <= d ? (w | node_mask) : (w & ~node_mask);
          vic_q <= d ? (vic_q | lvl_mask) : vic_q;
          idx_q <= {idx_q[IW-2:0], 1'b0} + IW'(1) + IW'(d);
          lvl_q <= lvl_q - LVL'(1);
        end
        WRITE: begin
          mem[set_q] <= w;
          way_h      <= op_q ? vic_q : way_q;
          set_h      <= set_q;
          plru_h     <= w;
        end
        default: ;
      endcase
    end
  end

  // During WRITE the live result is shown. Outside WRITE the held copy is
  // shown, so a new request does not disturb the outputs while it is loading.
  always_comb begin
    resp_way  = way_h;
    resp_set  = set_h;
    resp_plru = plru_h;
    if (st == WRITE) begin
      resp_way  = op_q ? vic_q : way_q;
      resp_set  = set_q;
      resp_plru = w;
    end
  end

endmodule
